// File: rtl/uart_core.sv
// uart_core: 8N1-style UART transmitter + receiver with valid/ready byte ports; optional parity via UART_PARITY_EN.
// Latency: TX start bit begins the clock after accept; rx_valid rises the clock after the RX stop-bit sample.
// Backpressure: tx_ready low while a frame is on the wire; RX has one holding register, a byte finishing while it is full is dropped (rx_overrun).
//
// Ports:
//   clk, rst_n            single rising-edge clock, asynchronous active-low reset
//   uart_rx / uart_tx     serial lines, both idle high
//   tx_data/tx_valid/tx_ready   byte to send, handshake (ready only while TX idle)
//   rx_data/rx_valid/rx_ready   last received byte, held until consumed
//   rx_frame_err, rx_parity_err, rx_overrun   single-cycle error pulses
// Optional feature macro: UART_PARITY_EN (adds a parity bit after the data bits, sense set by PARITY_ODD).
module uart_core #(
  parameter int DELAY_FRAMES = 234,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // Counter must hold the full two-bit stop period without wrapping.
  localparam int CNT_W = $clog2(DELAY_FRAMES * 2 + 1);
  localparam int BIT_W = 3;
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DELAY_FRAMES - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(DELAY_FRAMES / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS * DELAY_FRAMES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;

  // ---------------- RX ----------------
  logic                 sync1_q, sync2_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_bad_q, rx_par_bad_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_frame_err_q, rx_frame_err_d;
  logic                 rx_parity_err_q, rx_parity_err_d;
  logic                 rx_overrun_q, rx_overrun_d;
  logic                 rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    rx_state_d      = rx_state_q;
    rx_cnt_d        = rx_cnt_q;
    rx_bit_d        = rx_bit_q;
    rx_shift_d      = rx_shift_q;
    rx_par_bad_d    = rx_par_bad_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = rx_valid_q;
    rx_frame_err_d  = 1'b0;
    rx_parity_err_d = 1'b0;
    rx_overrun_d    = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s) rx_state_d = RX_START;
      end
      RX_START: begin
        // Mid-start-bit resample: a line already back high was a glitch.
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d     = '0;
          rx_bit_d     = '0;
          rx_par_bad_d = 1'b0;
          rx_state_d   = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + BIT_W'(1);
          if (rx_bit_q == LAST_BIT) begin
            if (PAR_EN) rx_state_d = RX_PARITY;
            else        rx_state_d = RX_STOP;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_PARITY: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d     = '0;
          rx_par_bad_d = rx_s ^ (^rx_shift_q) ^ PARITY_ODD;
          rx_state_d   = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (!rx_s) rx_frame_err_d = 1'b1;
          if (PAR_EN && rx_par_bad_q) rx_parity_err_d = 1'b1;
          if (rx_s && !(PAR_EN && rx_par_bad_q)) begin
            // Full holding register and no consumer this cycle: keep the old byte.
            if (rx_valid_q && !rx_ready) begin
              rx_overrun_d = 1'b1;
            end else begin
              rx_data_d  = rx_shift_q;
              rx_valid_d = 1'b1;
            end
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      rx_state_q      <= RX_IDLE;
      rx_cnt_q        <= '0;
      rx_bit_q        <= '0;
      rx_shift_q      <= '0;
      rx_par_bad_q    <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      rx_parity_err_q <= 1'b0;
      rx_overrun_q    <= 1'b0;
    end else begin
      sync1_q         <= uart_rx;
      sync2_q         <= sync1_q;
      rx_state_q      <= rx_state_d;
      rx_cnt_q        <= rx_cnt_d;
      rx_bit_q        <= rx_bit_d;
      rx_shift_q      <= rx_shift_d;
      rx_par_bad_q    <= rx_par_bad_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      rx_frame_err_q  <= rx_frame_err_d;
      rx_parity_err_q <= rx_parity_err_d;
      rx_overrun_q    <= rx_overrun_d;
    end
  end

  // ---------------- TX ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 uart_tx_q, uart_tx_d;
  logic                 tx_ready_q, tx_ready_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    uart_tx_d  = uart_tx_q;

    case (tx_state_q)
      TX_IDLE: begin
        uart_tx_d = 1'b1;
        tx_cnt_d  = '0;
        if (tx_valid && tx_ready_q) begin
          tx_state_d = TX_START;
          tx_shift_d = tx_data;
          tx_par_d   = (^tx_data) ^ PARITY_ODD;
          uart_tx_d  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
          uart_tx_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + BIT_W'(1);
          if (tx_bit_q == LAST_BIT) begin
            if (PAR_EN) begin
              tx_state_d = TX_PARITY;
              uart_tx_d  = tx_par_q;
            end else begin
              tx_state_d = TX_STOP;
              uart_tx_d  = 1'b1;
            end
          end else begin
            uart_tx_d = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_PARITY: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
          uart_tx_d  = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        uart_tx_d = 1'b1;
        if (tx_cnt_q == STOP_END) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // Registered so ready stays low through reset and rises one clock after it.
    tx_ready_d = (tx_state_d == TX_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      uart_tx_q  <= 1'b1;
      tx_ready_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      uart_tx_q  <= uart_tx_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign uart_tx       = uart_tx_q;
  assign tx_ready      = tx_ready_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_frame_err  = rx_frame_err_q;
  assign rx_parity_err = rx_parity_err_q;
  assign rx_overrun    = rx_overrun_q;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed bench for uart_core at default parameters.
// A frame-level model predicts uart_tx/tx_ready every cycle; RX outcomes are queued per frame and matched as they appear.
// Literal expectations for the 0x4C frame and the RX bytes pin the model.
module tb_uart_core;
  localparam int D  = 234;
  localparam int DB = 8;
  localparam bit PODD = 1'b0;
`ifdef UART_PARITY_EN
  localparam int P = 1;
  localparam int RDY_OFF = 2574;
`else
  localparam int P = 0;
  localparam int RDY_OFF = 2340;
`endif
  localparam int FRAME_LEN = (1 + DB + P + 1) * D;

  localparam int EV_VALID = 0;
  localparam int EV_FRAME = 1;
  localparam int EV_PAR   = 2;
  localparam int EV_OVR   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic       uart_tx;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rx      (uart_rx),
    .uart_tx      (uart_tx),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  bit         m_tx_act = 1'b0;
  int         m_off = 0;
  logic [7:0] m_frame = '0;
  bit         m_ready = 1'b0;
  bit         m_rx_valid = 1'b0;
  bit         m_held_ok = 1'b0;
  logic [7:0] m_held = '0;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         lo;
    int         hi;
  } ev_t;
  ev_t exp_q[$];

  // Line level at a given cycle offset into a frame: one bit per D cycles.
  function automatic logic exp_tx(input int off, input logic [7:0] f);
    int idx;
    idx = off / D;
    if (idx == 0) return 1'b0;
    if (idx <= DB) return f[idx-1];
    if (P == 1 && idx == DB + 1) return (^f) ^ PODD;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tx_act   = 1'b0;
      m_ready    = 1'b0;
      m_rx_valid = 1'b0;
    end else begin
      if (m_tx_act) begin
        m_off++;
        if (m_off == FRAME_LEN) begin
          m_tx_act = 1'b0;
          m_ready  = 1'b1;
        end
      end else if (m_ready && tx_valid) begin
        m_tx_act = 1'b1;
        m_off    = 0;
        m_frame  = tx_data;
        m_ready  = 1'b0;
      end else begin
        m_ready = 1'b1;
      end
      if (m_rx_valid && rx_ready) m_rx_valid = 1'b0;
    end
  end

  task automatic rx_event(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL rx_event: got unexpected event kind %0d expected none (cycle %0d)", kind, cyc);
      if (kind == EV_VALID) begin
        m_rx_valid = 1'b1;
        m_held_ok  = 1'b0;
      end
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || cyc < e.lo || cyc > e.hi) begin
      errors++;
      $display("FAIL rx_event: got kind %0d at cycle %0d expected kind %0d in [%0d,%0d]",
               kind, cyc, e.kind, e.lo, e.hi);
    end
    if (kind == EV_VALID) begin
      m_rx_valid = 1'b1;
      m_held_ok  = (e.kind == EV_VALID);
      m_held     = e.data;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_uart_tx", uart_tx, 1);
      chk("rst_tx_ready", tx_ready, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_errs", {rx_frame_err, rx_parity_err, rx_overrun}, 0);
    end else begin
      chk("uart_tx", uart_tx, m_tx_act ? exp_tx(m_off, m_frame) : 1'b1);
      chk("tx_ready", tx_ready, m_ready);
      if (rx_valid && !m_rx_valid) rx_event(EV_VALID);
      else chk("rx_valid", rx_valid, m_rx_valid);
      if (m_rx_valid && m_held_ok) chk("rx_data", rx_data, m_held);
      if (rx_frame_err)  rx_event(EV_FRAME);
      if (rx_parity_err) rx_event(EV_PAR);
      if (rx_overrun)    rx_event(EV_OVR);
    end
  end

  // ---------------- stimulus ----------------
  // Drives one frame on uart_rx and queues the outcome it should produce around the stop sample.
  task automatic send_frame(input logic [7:0] d, input bit bad_stop, input bit bad_par,
                            input int kind, input logic [7:0] exp_d);
    int e, nom;
    ev_t ev;
    @(posedge clk);
    #1;
    e = cyc;
    nom = e + ((2 * (1 + DB + P) + 1) * D) / 2;
    if (kind >= 0) begin
      ev.kind = kind;
      ev.data = exp_d;
      ev.lo   = nom - 4;
      ev.hi   = nom + 8;
      exp_q.push_back(ev);
    end
    uart_rx = 1'b0;
    repeat (D) @(posedge clk);
    #1;
    for (int i = 0; i < DB; i++) begin
      uart_rx = d[i];
      repeat (D) @(posedge clk);
      #1;
    end
    if (P == 1) begin
      uart_rx = (^d) ^ PODD ^ bad_par;
      repeat (D) @(posedge clk);
      #1;
    end
    uart_rx = ~bad_stop;
    repeat (D) @(posedge clk);
    #1;
    uart_rx = 1'b1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3 * D) begin
      @(negedge clk);
      n++;
    end
    chk("rx_events_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic consume();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("rx_valid_after_ready", rx_valid, 0);
  endtask

  logic lit_4c [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int t;
    rst_n    = 1'b0;
    uart_rx  = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("tx_ready_before_first_clk", tx_ready, 0);
    @(posedge clk);
    #1;
    chk("tx_ready_first_clk", tx_ready, 1);
    chk("uart_tx_idle", uart_tx, 1);

    // TX 0x4C, tx_data disturbed after accept.
    @(negedge clk);
    tx_data  = 8'h4C;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
    t = 0;
    for (int k = 0; k < 10; k++) begin
      repeat (k * D + D / 2 - t) @(posedge clk);
      #1;
      t = k * D + D / 2;
      chk($sformatf("tx_4c_bit%0d", k), uart_tx, lit_4c[k]);
    end
    repeat (RDY_OFF - 1 - t) @(posedge clk);
    #1;
    chk("tx_ready_busy_last", tx_ready, 0);
    @(posedge clk);
    #1;
    chk("tx_ready_back", tx_ready, 1);

    // Back-to-back frames with tx_valid held high.
    @(negedge clk);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    repeat (10) @(negedge clk);
    tx_data = 8'h3C;
    repeat (FRAME_LEN + 5) @(negedge clk);
    tx_valid = 1'b0;
    repeat (FRAME_LEN + 10) @(negedge clk);

    // RX good frame, then consume.
    send_frame(8'h75, 1'b0, 1'b0, EV_VALID, 8'h75);
    wait_drain();
    @(negedge clk);
    chk("rx_valid_75", rx_valid, 1);
    chk("rx_data_75", rx_data, 8'h75);
    consume();

    // Short low glitch: nothing must come out.
    @(posedge clk);
    #1;
    uart_rx = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (3 * D) @(negedge clk);
    chk("rx_valid_glitch", rx_valid, 0);

    // Overrun: second byte dropped, first held.
    send_frame(8'h11, 1'b0, 1'b0, EV_VALID, 8'h11);
    send_frame(8'h22, 1'b0, 1'b0, EV_OVR, 8'h00);
    wait_drain();
    @(negedge clk);
    chk("rx_data_kept_11", rx_data, 8'h11);
    chk("rx_valid_kept", rx_valid, 1);
    consume();

    // Low stop bit.
    send_frame(8'h55, 1'b1, 1'b0, EV_FRAME, 8'h00);
    wait_drain();
    repeat (2 * D) @(negedge clk);
    chk("rx_valid_frame_err", rx_valid, 0);

`ifdef UART_PARITY_EN
    send_frame(8'h5A, 1'b0, 1'b1, EV_PAR, 8'h00);
    wait_drain();
    repeat (D) @(negedge clk);
    chk("rx_valid_par_err", rx_valid, 0);
    send_frame(8'h96, 1'b0, 1'b0, EV_VALID, 8'h96);
    wait_drain();
    @(negedge clk);
    chk("rx_data_96", rx_data, 8'h96);
    consume();
`endif

    // Reset in the middle of a TX frame.
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    chk("uart_tx_mid_frame_low", uart_tx, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("uart_tx_async_reset", uart_tx, 1);
    chk("tx_ready_async_reset", tx_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("tx_ready_release", tx_ready, 0);
    @(posedge clk);
    #1;
    chk("tx_ready_after_release", tx_ready, 1);
    repeat (D) @(negedge clk);
    chk("uart_tx_no_resume", uart_tx, 1);

    repeat (20) @(negedge clk);
    chk("rx_queue_empty_end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter DELAY_FRAMES, default 234, meaning clocks per bit (27 MHz / 115200); legal range 4..8191.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..8.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning TX stop bits; legal values 1 or 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning parity sense (0 even, 1 odd); used only when UART_PARITY_EN is defined.
REQ-005 SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-007 SHALL have port uart_rx, input, 1 bit, asynchronous serial input, idle high.
REQ-008 SHALL have port uart_tx, output, 1 bit, serial output, idle high.
REQ-009 SHALL have port tx_data, input, DATA_BITS wide, byte to send.
REQ-010 SHALL have port tx_valid, input, 1 bit, tx_data is valid.
REQ-011 SHALL have port tx_ready, output, 1 bit, transmitter accepts data.
REQ-012 SHALL have port rx_data, output, DATA_BITS wide, last received byte.
REQ-013 SHALL have port rx_valid, output, 1 bit, rx_data holds an unread byte.
REQ-014 SHALL have port rx_ready, input, 1 bit, consumer takes rx_data.
REQ-015 SHALL have ports rx_frame_err, rx_parity_err and rx_overrun, each an output, 1 bit, single-cycle error pulses.

Function
REQ-016 SHALL pass uart_rx through a 2-flop synchronizer (initialised high); all RX timing refers to the synchronized signal.
REQ-017 SHALL use RX states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE->START: on a synchronized low.
- START: after DELAY_FRAMES/2 cycles, resamples the line; high -> IDLE (glitch reject), low -> DATA.
REQ-018 SHALL sample each data bit, LSB first, DELAY_FRAMES cycles after the previous sample point, for exactly DATA_BITS samples.
REQ-019 SHALL sample the stop bit one bit-time after the last data/parity sample; a low stop sample pulses rx_frame_err and discards the byte; RX checks exactly one stop bit regardless of STOP_BITS.
REQ-020 SHALL, on a good frame, load rx_data and set rx_valid on the clock after the stop sample; the RX FSM returns to IDLE on that same clock.
REQ-021 SHALL clear rx_valid on the clock after rx_valid && rx_ready; rx_data is held stable while rx_valid is high.
REQ-022 SHALL, when a good frame completes while rx_valid is high and rx_ready is low, keep the old rx_data, drop the new byte and pulse rx_overrun; if rx_ready is high in that same cycle, it loads the new byte with no overrun.
REQ-023 SHALL use TX states IDLE, START, DATA, [PARITY], STOP, with tx_ready high only in IDLE.
REQ-024 SHALL, on tx_valid && tx_ready, capture tx_data and drive uart_tx low (start bit) from the next clock.
REQ-025 SHALL hold every TX bit for exactly DELAY_FRAMES cycles: start, DATA_BITS data LSB first, [parity], then STOP_BITS*DELAY_FRAMES cycles high.
REQ-026 SHALL return TX to IDLE after the stop period, so back-to-back frames are separated by at least 1 idle-high cycle; tx_data changes outside IDLE have no effect.
REQ-027 SHALL keep bit counters wide enough for DELAY_FRAMES*2 with no wrap; a bit counter reaching DELAY_FRAMES-1 ends that bit.

Reset
REQ-028 SHALL, while rst_n is low, immediately force uart_tx=1, tx_ready=0, rx_valid=0, rx_data=0, all error pulses 0, both FSMs to IDLE, counters 0 and synchronizer flops to 1.
REQ-029 SHALL raise tx_ready on the first clock after rst_n deasserts; reset mid-frame truncates the frame, with no resumption.

Configuration
REQ-030 SHALL, with UART_PARITY_EN defined:
- TX inserts a parity bit (XOR of data bits, inverted if PARITY_ODD=1) after the data bits.
- RX samples the parity bit; on mismatch it pulses rx_parity_err together with the stop sample and discards the byte.
REQ-031 SHALL, with UART_PARITY_EN undefined, have no parity bit, keep rx_parity_err tied to 0, and ignore PARITY_ODD.

Verification
REQ-032 SHALL cover: defaults, tx_data=0x4C pulsed with tx_valid -> uart_tx low 234 cycles, then bits 0,0,1,1,0,0,1,0 at 234 cycles each, then high; tx_ready high again 2340 cycles after accept (+1).
REQ-033 SHALL cover: drive 8N1 frame 0x75 on uart_rx -> rx_valid=1, rx_data=0x75, no error pulses; rx_ready=1 one cycle -> rx_valid=0.
REQ-034 SHALL cover: 50-cycle low glitch on uart_rx -> no rx_valid and no errors, RX back in IDLE.
REQ-035 SHALL cover: two frames 0x11, 0x22 with rx_ready=0 -> rx_data stays 0x11, one rx_overrun pulse at the second stop sample.
REQ-036 SHALL cover: frame 0x55 with stop bit low -> rx_frame_err pulse, rx_valid stays 0; with UART_PARITY_EN, PARITY_ODD=0 and a wrong parity bit -> rx_parity_err pulse.
REQ-037 SHALL cover: rst_n low mid-TX-frame -> uart_tx=1 the same cycle (asynchronous), tx_ready=1 one clock after release.
